// File: rtl/pic_execute_sequencer.sv
// PIC16C5x instruction-cycle sequencer: Q1..Q4 phase generation, Q4 execute-state
// decode, branch/skip pipeline flush and the SLEEP halt/wake sequence.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// Q1..Q3     | first three clocks of an instruction cycle (IR decoded in Q3)
// Q4_*       | execute clock; code selects the write-control action
// Q4_NOP     | flushed cycle or unused encoding; no architectural effect
// EX_SLEEP   | halted after SLEEP, waiting for wakeIn
module pic_execute_sequencer #(
  parameter int INST_WIDTH    = 12,
  parameter int EX_STATE_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [INST_WIDTH-1:0]    IR,
  input  logic                     skipCond,
  input  logic                     wakeIn,
  output logic [EX_STATE_BITS-1:0] executeState,
  output logic                     flushOut,
  output logic                     sleepOut
);

  typedef enum logic [4:0] {
    Q1        = 5'd0,
    Q2        = 5'd1,
    Q3        = 5'd2,
    Q4_CLRF   = 5'd3,
    Q4_CLRW   = 5'd4,
    Q4_FSZ    = 5'd5,
    Q4_MOVF   = 5'd6,
    Q4_MOVWF  = 5'd7,
    Q4_BXF    = 5'd8,
    Q4_BTFSX  = 5'd9,
    Q4_CALL   = 5'd10,
    Q4_CLRWDT = 5'd11,
    Q4_GOTO   = 5'd12,
    Q4_MOVLW  = 5'd13,
    Q4_OPTION = 5'd14,
    Q4_RETLW  = 5'd15,
    Q4_SLEEP  = 5'd16,
    Q4_TRIS   = 5'd17,
    Q4_ELSE   = 5'd18,
    Q4_ALUXLW = 5'd19,
    Q4_NOP    = 5'd20,
    EX_SLEEP  = 5'd21
  } ex_state_e;

  ex_state_e   state_q, state_d;
  logic        flush_q, flush_d;
  logic        sleep_q, sleep_d;
  logic [11:0] ir_w;

  assign ir_w = IR[11:0];

  // Priority order matters: the special low encodings must win over the byte-op ranges.
  function automatic ex_state_e decode_ir(input logic [11:0] ir);
    ex_state_e d;
    if (ir == 12'h000)                              d = Q4_NOP;
    else if (ir == 12'h002)                         d = Q4_OPTION;
    else if (ir == 12'h003)                         d = Q4_SLEEP;
    else if (ir == 12'h004)                         d = Q4_CLRWDT;
    else if (ir >= 12'h005 && ir <= 12'h007)        d = Q4_TRIS;
    else if (ir == 12'h001)                         d = Q4_NOP;
    else if (ir >= 12'h041 && ir <= 12'h05F)        d = Q4_NOP;
    else if (ir >= 12'h020 && ir <= 12'h03F)        d = Q4_MOVWF;
    else if (ir == 12'h040)                         d = Q4_CLRW;
    else if (ir >= 12'h060 && ir <= 12'h07F)        d = Q4_CLRF;
    else if (ir[11:6] == 6'b001000)                 d = Q4_MOVF;
    else if (ir[11:6] == 6'b001011 ||
             ir[11:6] == 6'b001111)                 d = Q4_FSZ;
    else if (ir[11:10] == 2'b00)                    d = Q4_ELSE;
    else if (ir[11:9] == 3'b010)                    d = Q4_BXF;
    else if (ir[11:9] == 3'b011)                    d = Q4_BTFSX;
    else if (ir[11:8] == 4'b1000)                   d = Q4_RETLW;
    else if (ir[11:8] == 4'b1001)                   d = Q4_CALL;
    else if (ir[11:9] == 3'b101)                    d = Q4_GOTO;
    else if (ir[11:8] == 4'b1100)                   d = Q4_MOVLW;
    else                                            d = Q4_ALUXLW;
    return d;
  endfunction

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    case (state_q)
      Q1: state_d = Q2;
      Q2: state_d = Q3;
      Q3: state_d = flush_q ? Q4_NOP : decode_ir(ir_w);
      Q4_SLEEP: state_d = EX_SLEEP;
      EX_SLEEP: begin
        if (wakeIn) begin
          state_d = Q1;
          flush_d = 1'b1;
        end
      end
      Q4_GOTO, Q4_CALL, Q4_RETLW: begin
        state_d = Q1;
        flush_d = 1'b1;
      end
      Q4_FSZ, Q4_BTFSX: begin
        state_d = Q1;
        flush_d = skipCond;
      end
      Q4_CLRF, Q4_CLRW, Q4_MOVF, Q4_MOVWF, Q4_BXF, Q4_CLRWDT, Q4_MOVLW,
      Q4_OPTION, Q4_TRIS, Q4_ELSE, Q4_ALUXLW, Q4_NOP: begin
        state_d = Q1;
        flush_d = 1'b0;
      end
      // Unused codes recover into a harmless NOP cycle.
      default: begin
        state_d = Q1;
        flush_d = 1'b1;
      end
    endcase
    sleep_d = (state_d == EX_SLEEP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= Q1;
      flush_q <= 1'b1;
      sleep_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      sleep_q <= sleep_d;
    end
  end

  assign executeState = EX_STATE_BITS'(state_q);
  assign flushOut     = flush_q;
  assign sleepOut     = sleep_q;

endmodule

// File: tb/tb_pic_execute_sequencer.sv
// Directed bench for pic_execute_sequencer: expected phase/flush/sleep values are
// queued per clock and compared one clock later with immediate assertions.
module tb_pic_execute_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] IR;
  logic        skipCond;
  logic        wakeIn;
  logic [4:0]  executeState;
  logic        flushOut;
  logic        sleepOut;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  typedef struct {
    logic [4:0] st;
    logic       fl;
    logic       sl;
    string      tag;
  } exp_t;

  exp_t sb[$];

  pic_execute_sequencer #(.INST_WIDTH(12), .EX_STATE_BITS(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IR           (IR),
    .skipCond     (skipCond),
    .wakeIn       (wakeIn),
    .executeState (executeState),
    .flushOut     (flushOut),
    .sleepOut     (sleepOut)
  );

  always #5 clk = ~clk;

  // Reference decode organised by opcode field rather than by range chain.
  function automatic logic [4:0] tb_decode(input logic [11:0] ir);
    logic [4:0] c;
    if (ir[11:10] == 2'b00) begin
      case (ir[11:6])
        6'b000000: begin
          case (ir[5:0])
            6'd0, 6'd1:       c = 5'd20;
            6'd2:             c = 5'd14;
            6'd3:             c = 5'd16;
            6'd4:             c = 5'd11;
            6'd5, 6'd6, 6'd7: c = 5'd17;
            default:          c = ir[5] ? 5'd7 : 5'd18;
          endcase
        end
        6'b000001: begin
          if (ir[5:0] == 6'd0) c = 5'd4;
          else if (!ir[5])     c = 5'd20;
          else                 c = 5'd3;
        end
        6'b001000:            c = 5'd6;
        6'b001011, 6'b001111: c = 5'd5;
        default:              c = 5'd18;
      endcase
    end else begin
      casez (ir[11:8])
        4'b010?: c = 5'd8;
        4'b011?: c = 5'd9;
        4'b1000: c = 5'd15;
        4'b1001: c = 5'd10;
        4'b101?: c = 5'd12;
        4'b1100: c = 5'd13;
        default: c = 5'd19;
      endcase
    end
    return c;
  endfunction

  task automatic step(input logic [4:0] st, input logic fl, input logic sl, input string tag);
    exp_t e;
    exp_t x;
    e.st = st;
    e.fl = fl;
    e.sl = sl;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    total++;
    assert (executeState === x.st) passed++;
    else begin
      fails++;
      $error("FAIL %s state got %0d exp %0d", x.tag, executeState, x.st);
    end
    total++;
    assert (flushOut === x.fl) passed++;
    else begin
      fails++;
      $error("FAIL %s flushOut got %b exp %b", x.tag, flushOut, x.fl);
    end
    total++;
    assert (sleepOut === x.sl) passed++;
    else begin
      fails++;
      $error("FAIL %s sleepOut got %b exp %b", x.tag, sleepOut, x.sl);
    end
  endtask

  // Called with the DUT in Q1; checks Q2, Q3, Q4 and the state after Q4.
  task automatic cycle(input logic [11:0] ir, input logic skip, input logic [4:0] q4,
                       input logic fl, input logic [4:0] nst, input logic nfl,
                       input logic nsl, input string tag);
    IR = ir;
    skipCond = 1'b0;
    step(5'd1, fl, 1'b0, tag);
    step(5'd2, fl, 1'b0, tag);
    step(q4, fl, 1'b0, tag);
    skipCond = skip;
    step(nst, nfl, nsl, tag);
    skipCond = 1'b0;
  endtask

  task automatic cyc(input logic [11:0] ir, input logic skip, input logic [4:0] q4,
                     input logic fl, input logic nfl, input string tag);
    cycle(ir, skip, q4, fl, 5'd0, nfl, 1'b0, tag);
  endtask

  initial begin
    logic [11:0] v;
    logic [4:0]  c;
    rst_n = 1'b0;
    IR = 12'hC5A;
    skipCond = 1'b0;
    wakeIn = 1'b0;
    step(5'd0, 1'b1, 1'b0, "reset");
    rst_n = 1'b1;

    cyc(12'hC5A, 1'b0, 5'd20, 1'b1, 1'b0, "movlw_first");
    cyc(12'hC5A, 1'b0, 5'd13, 1'b0, 1'b0, "movlw");
    cyc(12'hA10, 1'b0, 5'd12, 1'b0, 1'b1, "goto");
    cyc(12'h1E5, 1'b0, 5'd20, 1'b1, 1'b0, "goto_shadow");
    cyc(12'h1E5, 1'b0, 5'd18, 1'b0, 1'b0, "addwf");
    cyc(12'h2E5, 1'b1, 5'd5,  1'b0, 1'b1, "decfsz_skip");
    cyc(12'hC5A, 1'b0, 5'd20, 1'b1, 1'b0, "skipped");
    cyc(12'h2E5, 1'b0, 5'd5,  1'b0, 1'b0, "decfsz_noskip");
    cyc(12'hA10, 1'b0, 5'd12, 1'b0, 1'b1, "goto2");
    cyc(12'hA10, 1'b0, 5'd20, 1'b1, 1'b0, "goto_no_chain");
    cyc(12'h605, 1'b1, 5'd9,  1'b0, 1'b1, "btfsc_skip");
    cyc(12'h605, 1'b1, 5'd20, 1'b1, 1'b0, "btfsc_flushed");
    cyc(12'h905, 1'b0, 5'd10, 1'b0, 1'b1, "call");
    cyc(12'h003, 1'b0, 5'd20, 1'b1, 1'b0, "flushed_sleep");
    cyc(12'h8FF, 1'b0, 5'd15, 1'b0, 1'b1, "retlw");
    cyc(12'hC5A, 1'b0, 5'd20, 1'b1, 1'b0, "retlw_shadow");
    wakeIn = 1'b1;
    cyc(12'hC5A, 1'b0, 5'd13, 1'b0, 1'b0, "wake_ignored");
    wakeIn = 1'b0;

    cycle(12'h003, 1'b0, 5'd16, 1'b0, 5'd21, 1'b0, 1'b1, "sleep");
    for (int k = 0; k < 10; k++) step(5'd21, 1'b0, 1'b1, "sleep_hold");
    wakeIn = 1'b1;
    step(5'd0, 1'b1, 1'b0, "wake");
    wakeIn = 1'b0;
    cyc(12'hC5A, 1'b0, 5'd20, 1'b1, 1'b0, "post_wake");

    IR = 12'hC5A;
    step(5'd1, 1'b0, 1'b0, "pre_rst");
    step(5'd2, 1'b0, 1'b0, "pre_rst");
    rst_n = 1'b0;
    step(5'd0, 1'b1, 1'b0, "rst_q3");
    rst_n = 1'b1;
    cyc(12'hC5A, 1'b0, 5'd20, 1'b1, 1'b0, "after_rst_q3");

    cycle(12'h003, 1'b0, 5'd16, 1'b0, 5'd21, 1'b0, 1'b1, "sleep2");
    step(5'd21, 1'b0, 1'b1, "sleep2_hold");
    rst_n = 1'b0;
    step(5'd0, 1'b1, 1'b0, "rst_sleep");
    rst_n = 1'b1;
    cyc(12'hC5A, 1'b0, 5'd20, 1'b1, 1'b0, "after_rst_sleep");

    for (int i = 0; i < 4096; i++) begin
      v = i[11:0];
      c = tb_decode(v);
      if (c == 5'd16) begin
        cycle(v, 1'b0, c, 1'b0, 5'd21, 1'b0, 1'b1, $sformatf("sweep_%03h", v));
        wakeIn = 1'b1;
        step(5'd0, 1'b1, 1'b0, "sweep_wake");
        wakeIn = 1'b0;
        cyc(12'hC5A, 1'b0, 5'd20, 1'b1, 1'b0, "sweep_fill");
      end else if (c == 5'd12 || c == 5'd10 || c == 5'd15) begin
        cyc(v, 1'b0, c, 1'b0, 1'b1, $sformatf("sweep_%03h", v));
        cyc(12'hC5A, 1'b0, 5'd20, 1'b1, 1'b0, "sweep_fill");
      end else begin
        cyc(v, 1'b0, c, 1'b0, 1'b0, $sformatf("sweep_%03h", v));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
